// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned PKG_XLEN  = 32;
   localparam int unsigned INS_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [PKG_XLEN-1:0] ins;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: power-of-two FIFO of {pc, ins} with flush and concurrent push/pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   // Qualify push/pop against occupancy; a push into a full queue is legal only with a pop.
   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
   end

   // Storage, pointers and occupancy; flush drops contents but keeps stale data words.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding imem
// requests, prefetch queue towards the decoder, redirect flush.
// Optional: FETCH_MISALIGN_TRAP_EN adds a sticky fetch_fault on misaligned redirects.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = PKG_XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            ins_valid,
   input  logic            ins_ready,
   output logic [XLEN-1:0] ins,
   output logic [XLEN-1:0] ins_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_fault
`endif
);

   localparam int unsigned     CW         = $clog2(DEPTH + 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INS_BYTES - 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            discard_q, discard_d;
   logic            imem_req_q, imem_req_d;
   logic            halt_eff;
   logic            push;
   logic            pop;
   logic [CW:0]     occ_after;
   logic            can_issue;
   logic [CW-1:0]   q_count;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   logic bad_redirect;

   // A misaligned redirect latches a sticky fault that blocks any further issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (bad_redirect) begin
         fault_q <= 1'b1;
      end
   end

   assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign halt_eff     = halt || fault_q || bad_redirect;
   assign fetch_fault  = fault_q;
`else
   assign halt_eff = halt;
`endif

   // Next-state, PC update and queue control; redirect overrides the normal flow.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      discard_d  = discard_q;
      push       = (state_q == WAIT) && imem_rvalid && !discard_q && !redirect_valid;
      pop        = ins_valid && ins_ready && !redirect_valid;
      occ_after  = redirect_valid ? '0
                 : ({1'b0, q_count} + (CW+1)'(push) - (CW+1)'(pop));
      can_issue  = !halt_eff && (occ_after < (CW+1)'(DEPTH));

      case (state_q)
         IDLE: begin
            if (can_issue) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (imem_gnt) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + XLEN'(INS_BYTES);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               discard_d = 1'b0;
               state_d   = can_issue ? REQ : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         case (state_q)
            REQ: begin
               if (imem_gnt) begin
                  discard_d = 1'b1;
                  state_d   = WAIT;
               end else begin
                  state_d = IDLE;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  discard_d = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end

      imem_req_d = (state_d == REQ);
   end

   // State and fetch-address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC & ALIGN_MASK;
         req_pc_q   <= '0;
         discard_q  <= 1'b0;
         imem_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
         imem_req_q <= imem_req_d;
      end
   end

   assign push_entry.pc  = PKG_XLEN'(req_pc_q);
   assign push_entry.ins = PKG_XLEN'(imem_rdata);

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (q_count)
   );

   assign imem_req  = imem_req_q;
   assign imem_addr = fetch_pc_q;
   assign ins_valid = (q_count != '0);
   assign ins       = XLEN'(head.ins);
   assign ins_pc    = XLEN'(head.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a req/gnt/rvalid memory model and an
// expected-instruction scoreboard compared on every decoder pop.
module tb_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins;
   logic [31:0] ins_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_fault;
`endif

   logic        gnt_en;
   int          resp_lat;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_wait;
   exp_t        exp_q[$];
   int          n_checks;
   int          n_pass;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ins            (ins),
      .ins_pc         (ins_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_fault    (fetch_fault)
`endif
   );

   always #5 clk = ~clk;

   assign imem_gnt = imem_req & gnt_en;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h0000_0013;
   endfunction

   // Memory: accepts on req&gnt, answers resp_lat cycles after the grant cycle.
   always @(posedge clk) begin
      if (rst) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
         pend        <= 1'b0;
      end else begin
         imem_rvalid <= 1'b0;
         if (pend) begin
            if (pend_wait == 0) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= word_of(pend_addr);
               pend        <= 1'b0;
            end else begin
               pend_wait <= pend_wait - 1;
            end
         end
         if (imem_req && imem_gnt) begin
            if (resp_lat == 0) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= word_of(imem_addr);
            end else begin
               pend      <= 1'b1;
               pend_addr <= imem_addr;
               pend_wait <= resp_lat - 1;
            end
         end
      end
   end

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      ins_ready      = 1'b0;
      gnt_en         = 1'b0;
      resp_lat       = 0;
      repeat (2) @(negedge clk);
      exp_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst       = 1'b0;
      gnt_en    = 1'b1;
      ins_ready = 1'b0;
      repeat (12) @(negedge clk);
      do_reset();
      n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem_req); else n_pass++;
      n_checks++; if (ins_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", ins_valid); else n_pass++;
      n_checks++; if (ins !== 32'h0) $display("FAIL reset_ins got %h want 0", ins); else n_pass++;
      n_checks++; if (ins_pc !== 32'h0) $display("FAIL reset_ins_pc got %h want 0", ins_pc); else n_pass++;
      n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
      n_checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", fetch_fault); else n_pass++;
`endif
   endtask

   task automatic test_sequential();
      int   first_valid;
      int   pops;
      int   last_pop;
      exp_t e;
      do_reset();
      gnt_en    = 1'b1;
      ins_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back('{32'(i * 4), word_of(32'(i * 4))});
      rst         = 1'b0;
      first_valid = -1;
      pops        = 0;
      last_pop    = -1;
      for (int k = 1; k <= 40 && pops < 4; k++) begin
         @(negedge clk);
         if (ins_valid && first_valid < 0) first_valid = k;
         if (ins_valid && ins_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL seq_unexpected got pc %h want none", ins_pc);
            end else begin
               n_pass++;
               e = exp_q.pop_front();
               n_checks++; if (ins_pc !== e.pc) $display("FAIL seq_pc got %h want %h", ins_pc, e.pc); else n_pass++;
               n_checks++; if (ins !== e.ins) $display("FAIL seq_ins got %h want %h", ins, e.ins); else n_pass++;
            end
            pops++;
            last_pop = k;
         end
      end
      n_checks++; if (first_valid != 3) $display("FAIL seq_first_valid got %0d want 3", first_valid); else n_pass++;
      n_checks++; if (pops != 4) $display("FAIL seq_pops got %0d want 4", pops); else n_pass++;
      n_checks++; if (last_pop != 9) $display("FAIL seq_throughput got %0d want 9", last_pop); else n_pass++;
   endtask

   task automatic test_full();
      int grants;
      do_reset();
      gnt_en    = 1'b1;
      ins_ready = 1'b0;
      rst       = 1'b0;
      grants    = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            n_checks++;
            if (imem_addr !== 32'(grants * 4)) $display("FAIL full_addr got %h want %h", imem_addr, 32'(grants * 4));
            else n_pass++;
            exp_q.push_back('{32'(grants * 4), word_of(32'(grants * 4))});
            grants++;
         end
      end
      n_checks++; if (grants != 4) $display("FAIL full_grants got %0d want 4", grants); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL full_req got %0b want 0", imem_req); else n_pass++;
      n_checks++; if (ins_valid !== 1'b1) $display("FAIL full_valid got %0b want 1", ins_valid); else n_pass++;
      n_checks++; if (ins_pc !== 32'h0) $display("FAIL full_head_pc got %h want 0", ins_pc); else n_pass++;
   endtask

   task automatic test_halt();
      int   reqs;
      bit   seen;
      exp_t e;
      halt      = 1'b1;
      ins_ready = 1'b1;
      reqs      = 0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (!(ins_valid && exp_q.size() != 0)) begin
            $display("FAIL halt_pop_missing got valid %0b want 1", ins_valid);
         end else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++; if (ins_pc !== e.pc) $display("FAIL halt_pc got %h want %h", ins_pc, e.pc); else n_pass++;
            n_checks++; if (ins !== e.ins) $display("FAIL halt_ins got %h want %h", ins, e.ins); else n_pass++;
         end
         @(negedge clk);
         if (imem_req) reqs++;
      end
      n_checks++; if (ins_valid !== 1'b0) $display("FAIL halt_drained got %0b want 0", ins_valid); else n_pass++;
      repeat (6) begin
         @(negedge clk);
         if (imem_req) reqs++;
      end
      n_checks++; if (reqs != 0) $display("FAIL halt_reqs got %0d want 0", reqs); else n_pass++;
      halt = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
         @(negedge clk);
         if (imem_req) seen = 1'b1;
      end
      n_checks++; if (!seen) $display("FAIL halt_resume got req 0 want 1"); else n_pass++;
      n_checks++; if (imem_addr !== 32'h10) $display("FAIL halt_resume_addr got %h want 00000010", imem_addr); else n_pass++;
   endtask

   task automatic test_redirect_wait();
      int          pops;
      logic [31:0] first_addr;
      bit          have_addr;
      exp_t        e;
      do_reset();
      gnt_en    = 1'b1;
      resp_lat  = 1;
      ins_ready = 1'b1;
      rst       = 1'b0;
      for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) $display("FAIL rw_req_timeout got %0b want 1", imem_req); else n_pass++;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      exp_q.delete();
      n_checks++; if (ins_valid !== 1'b0) $display("FAIL rw_valid0 got %0b want 0", ins_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (ins_valid !== 1'b0) $display("FAIL rw_dropped got %0b want 0", ins_valid); else n_pass++;
      exp_q.push_back('{32'h100, word_of(32'h100)});
      exp_q.push_back('{32'h104, word_of(32'h104)});
      pops      = 0;
      have_addr = 1'b0;
      first_addr = '0;
      for (int k = 0; k < 30 && pops < 2; k++) begin
         if (imem_req && !have_addr) begin
            first_addr = imem_addr;
            have_addr  = 1'b1;
         end
         if (ins_valid && ins_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL rw_unexpected got pc %h want none", ins_pc);
            end else begin
               n_pass++;
               e = exp_q.pop_front();
               n_checks++; if (ins_pc !== e.pc) $display("FAIL rw_pc got %h want %h", ins_pc, e.pc); else n_pass++;
               n_checks++; if (ins !== e.ins) $display("FAIL rw_ins got %h want %h", ins, e.ins); else n_pass++;
            end
            pops++;
         end
         @(negedge clk);
      end
      n_checks++; if (first_addr !== 32'h100) $display("FAIL rw_first_addr got %h want 00000100", first_addr); else n_pass++;
      n_checks++; if (pops != 2) $display("FAIL rw_pops got %0d want 2", pops); else n_pass++;
   endtask

   task automatic test_redirect_req();
      int          pops;
      logic [31:0] first_addr;
      bit          have_addr;
      exp_t        e;
      do_reset();
      ins_ready = 1'b1;
      rst       = 1'b0;
      for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) $display("FAIL rr_req_timeout got %0b want 1", imem_req); else n_pass++;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL rr_hold got req %0b addr %h want 1 0", imem_req, imem_addr);
         else n_pass++;
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL rr_withdraw got %0b want 0", imem_req); else n_pass++;
      gnt_en = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back('{32'h200 + 32'(i * 4), word_of(32'h200 + 32'(i * 4))});
      pops       = 0;
      have_addr  = 1'b0;
      first_addr = '0;
      for (int k = 0; k < 30 && pops < 3; k++) begin
         if (imem_req && !have_addr) begin
            first_addr = imem_addr;
            have_addr  = 1'b1;
         end
         if (ins_valid && ins_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL rr_unexpected got pc %h want none", ins_pc);
            end else begin
               n_pass++;
               e = exp_q.pop_front();
               n_checks++; if (ins_pc !== e.pc) $display("FAIL rr_pc got %h want %h", ins_pc, e.pc); else n_pass++;
               n_checks++; if (ins !== e.ins) $display("FAIL rr_ins got %h want %h", ins, e.ins); else n_pass++;
            end
            pops++;
         end
         @(negedge clk);
      end
      n_checks++; if (first_addr !== 32'h200) $display("FAIL rr_first_addr got %h want 00000200", first_addr); else n_pass++;
      n_checks++; if (pops != 3) $display("FAIL rr_pops got %0d want 3", pops); else n_pass++;
   endtask

`ifdef FETCH_MISALIGN_TRAP_EN
   task automatic test_fault();
      int reqs;
      do_reset();
      gnt_en    = 1'b1;
      ins_ready = 1'b1;
      rst       = 1'b0;
      for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) $display("FAIL ft_req_timeout got %0b want 1", imem_req); else n_pass++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_checks++; if (fetch_fault !== 1'b1) $display("FAIL ft_fault got %0b want 1", fetch_fault); else n_pass++;
      reqs = 0;
      repeat (20) begin
         if (imem_req) reqs++;
         @(negedge clk);
      end
      n_checks++; if (reqs != 0) $display("FAIL ft_reqs got %0d want 0", reqs); else n_pass++;
      n_checks++; if (fetch_fault !== 1'b1) $display("FAIL ft_sticky got %0b want 1", fetch_fault); else n_pass++;
      do_reset();
      n_checks++; if (fetch_fault !== 1'b0) $display("FAIL ft_clear got %0b want 0", fetch_fault); else n_pass++;
   endtask
`else
   task automatic test_misalign_wrap();
      int          pops;
      logic [31:0] first_addr;
      bit          have_addr;
      exp_t        e;
      do_reset();
      gnt_en    = 1'b1;
      ins_ready = 1'b1;
      rst       = 1'b0;
      for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) $display("FAIL mw_req_timeout got %0b want 1", imem_req); else n_pass++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      @(negedge clk);
      redirect_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back('{32'hFFFF_FFFC, word_of(32'hFFFF_FFFC)});
      exp_q.push_back('{32'h0000_0000, word_of(32'h0000_0000)});
      exp_q.push_back('{32'h0000_0004, word_of(32'h0000_0004)});
      pops       = 0;
      have_addr  = 1'b0;
      first_addr = '0;
      for (int k = 0; k < 30 && pops < 3; k++) begin
         if (imem_req && !have_addr) begin
            first_addr = imem_addr;
            have_addr  = 1'b1;
         end
         if (ins_valid && ins_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL mw_unexpected got pc %h want none", ins_pc);
            end else begin
               n_pass++;
               e = exp_q.pop_front();
               n_checks++; if (ins_pc !== e.pc) $display("FAIL mw_pc got %h want %h", ins_pc, e.pc); else n_pass++;
               n_checks++; if (ins !== e.ins) $display("FAIL mw_ins got %h want %h", ins, e.ins); else n_pass++;
            end
            pops++;
         end
         @(negedge clk);
      end
      n_checks++; if (first_addr !== 32'hFFFF_FFFC) $display("FAIL mw_first_addr got %h want fffffffc", first_addr); else n_pass++;
      n_checks++; if (pops != 3) $display("FAIL mw_pops got %0d want 3", pops); else n_pass++;
   endtask
`endif

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      ins_ready      = 1'b0;
      gnt_en         = 1'b0;
      resp_lat       = 0;
      repeat (2) @(negedge clk);
      test_reset();
      test_sequential();
      test_full();
      test_halt();
      test_redirect_wait();
      test_redirect_req();
`ifdef FETCH_MISALIGN_TRAP_EN
      test_fault();
`else
      test_misalign_wrap();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
